muldiv_sequencer: RTL

- Multi-cycle controller that performs 32x32 multiply (64-bit product) and 32/32 divide (quotient and remainder).
- It does not have its own adder. It borrows the core's 32-bit ALU (AND/OR/ADD/SUB/SLT, 3-bit control, `zero` flag) for one add or subtract per iteration.
- It sits beside the main datapath. While `alu_req` is high, the top level muxes the ALU operands and control from this block.
- Results go into HI/LO-style output registers.

---
 rtl/muldiv_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle 32x32 multiply / 32/32 divide sequencer that borrows the core ALU for one add/sub per iteration.
// Optional signed operation is enabled by defining MULDIV_SIGNED_EN (adds the sgn port and a FIX cycle).
module muldiv_sequencer #(
    parameter int ITER = 32,
    parameter int CNTW = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
`ifdef MULDIV_SIGNED_EN
    input  logic        sgn,
`endif
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero,
    output logic        alu_req,
    output logic [31:0] alu_srca,
    output logic [31:0] alu_srcb,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_result
);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

`ifdef MULDIV_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2, S_FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2} state_t;
`endif

    // Handshake: start is only looked at in IDLE (no queuing); busy is high while an
    // operation is in flight; done pulses one cycle and hi/lo/div_by_zero are valid from then on.
    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [31:0]     p;
    logic [31:0]     m;
    logic [31:0]     opnd;
    logic            op_q;
    logic [31:0]     a_in;
    logic [31:0]     b_in;
    logic [31:0]     p_nxt;
    logic [31:0]     m_nxt;
    logic [31:0]     sh;
    logic            carry;
    logic            take;

`ifdef MULDIV_SIGNED_EN
    logic neg_q;
    logic rneg_q;
    assign a_in = (sgn && a[31]) ? (32'd0 - a) : a;
    assign b_in = (sgn && b[31]) ? (32'd0 - b) : b;
`else
    assign a_in = a;
    assign b_in = b;
`endif

    // p/m hold P/M while multiplying and R/Q while dividing.
    assign sh    = {p[30:0], m[31]};
    assign carry = (alu_result < p);
    assign take  = p[31] || (sh >= opnd);

    always_comb begin
        p_nxt = p;
        m_nxt = m;
        if (!op_q) begin
            p_nxt = {carry, alu_result[31:1]};
            m_nxt = {alu_result[0], m[31:1]};
        end else if (take) begin
            p_nxt = alu_result;
            m_nxt = {m[30:0], 1'b1};
        end else begin
            p_nxt = sh;
            m_nxt = {m[30:0], 1'b0};
        end
    end

    always_comb begin
        alu_srca    = '0;
        alu_srcb    = '0;
        alu_control = ALU_ADD;
        if (state == S_ITER) begin
            if (!op_q) begin
                alu_srca = p;
                alu_srcb = m[0] ? opnd : 32'd0;
            end else begin
                alu_srca    = sh;
                alu_srcb    = opnd;
                alu_control = ALU_SUB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            p           <= '0;
            m           <= '0;
            opnd        <= '0;
            op_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            alu_req     <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        cnt  <= '0;
                        if (op && (b == 32'd0)) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            hi          <= a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= S_ITER;
                            busy        <= 1'b1;
                            alu_req     <= 1'b1;
                            div_by_zero <= 1'b0;
                            p           <= '0;
                            m           <= op ? a_in : b_in;
                            opnd        <= op ? b_in : a_in;
`ifdef MULDIV_SIGNED_EN
                            neg_q       <= sgn && (a[31] ^ b[31]);
                            rneg_q      <= sgn && a[31];
`endif
                        end
                    end
                end
                S_ITER: begin
                    p   <= p_nxt;
                    m   <= m_nxt;
                    cnt <= cnt + CNTW'(1);
                    if (cnt == CNTW'(ITER - 1)) begin
                        alu_req <= 1'b0;
`ifdef MULDIV_SIGNED_EN
                        state   <= S_FIX;
`else
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        hi      <= p_nxt;
                        lo      <= m_nxt;
                        state   <= S_DONE;
`endif
                    end
                end
`ifdef MULDIV_SIGNED_EN
                S_FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                    if (!op_q) begin
                        {hi, lo} <= neg_q ? (64'd0 - {p, m}) : {p, m};
                    end else begin
                        lo <= neg_q ? (32'd0 - m) : m;
                        hi <= rneg_q ? (32'd0 - p) : p;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
